// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit for the execute stage: 32-step shift-add multiply,
// 32-step restoring divide, owns HI/LO and stalls the pipeline while in flight.
module mdu_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flushE,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic        is_div_q;
    logic        neg_res_q;
    logic        neg_rem_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        done_q;

    logic        accept;
    logic        signed_op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_acc_d;
    logic [32:0] div_trial;
    logic [63:0] div_acc_d;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign accept    = (state_q == S_IDLE) && start && !flushE;
    assign signed_op = !op[2] && !op[0];
    assign sign_a    = signed_op && src_a[31];
    assign sign_b    = signed_op && src_b[31];
    assign mag_a     = sign_a ? -src_a : src_a;
    assign mag_b     = sign_b ? -src_b : src_b;

    // Multiply: acc = {partial product, remaining multiplier bits}; shift right each step.
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_acc_d = {mul_sum, acc_q[31:1]};

    // Divide: acc = {remainder, dividend/quotient}; 33-bit trial subtraction each step.
    assign div_trial = acc_q[63:31] - {1'b0, opnd_q};
    assign div_acc_d = div_trial[32] ? {acc_q[62:0], 1'b0}
                                     : {div_trial[31:0], acc_q[30:0], 1'b1};

    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = (opnd_q == 32'd0) ? 32'hFFFF_FFFF
                    : (neg_res_q ? -acc_q[31:0] : acc_q[31:0]);
    assign rem_fix  = neg_rem_q ? -acc_q[63:32] : acc_q[63:32];

    assign busy = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX)
               || (accept && !op[2]);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 5'd0;
            acc_q     <= 64'd0;
            opnd_q    <= 32'd0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        case (op)
                            3'd0, 3'd1: begin
                                acc_q     <= {32'd0, mag_b};
                                opnd_q    <= mag_a;
                                is_div_q  <= 1'b0;
                                neg_res_q <= sign_a ^ sign_b;
                                neg_rem_q <= 1'b0;
                                cnt_q     <= 5'd0;
                                state_q   <= S_MUL;
                            end
                            3'd2, 3'd3: begin
                                acc_q     <= {32'd0, mag_a};
                                opnd_q    <= mag_b;
                                is_div_q  <= 1'b1;
                                neg_res_q <= sign_a ^ sign_b;
                                neg_rem_q <= sign_a;
                                cnt_q     <= 5'd0;
                                state_q   <= S_DIV;
                            end
                            3'd4:    hi_q <= src_a;
                            3'd5:    lo_q <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL, S_DIV: begin
                    if (flushE) begin
                        state_q <= S_IDLE;
                    end else begin
                        acc_q <= (state_q == S_MUL) ? mul_acc_d : div_acc_d;
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'(ITER - 1)) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (flushE) begin
                        state_q <= S_IDLE;
                    end else begin
                        if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end else begin
                            hi_q <= prod_fix[63:32];
                            lo_q <= prod_fix[31:0];
                        end
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
